obi_sram_responder: RTL and testbench

- OBI device-side endpoint: accepts requests from an OBI host (e.g. instruction/data fetch drivers), generates gnt/rvalid, and services them from an internal byte-enabled 64-bit word memory.
- Configurable grant wait-states and response latency; used as the on-chip scratchpad and as the bench responder for host-side drivers.
- Supports at most one read outstanding.
- rvalid is returned for reads only; writes complete at grant.

---
 rtl/obi_sram_responder_pkg.sv | 22 ++
 rtl/obi_sram_array.sv | 32 +++
 rtl/obi_sram_responder.sv | 142 ++++++++++++++
 tb/tb_obi_sram_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/obi_sram_responder_pkg.sv
// Shared OBI bus widths, FSM state encoding and response record for the SRAM responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obi_sram_responder_pkg;

  localparam int OBI_DATA_W = 64;
  localparam int OBI_BE_W   = 8;
  localparam int OBI_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RD_PEND  = 2'd2
  } state_e;

  // Read response captured at the accept edge and replayed on rvalid.
  typedef struct packed {
    logic                  err;
    logic [OBI_DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/obi_sram_array.sv
// Single-port byte-enable word memory: synchronous write, combinational read of the addressed word.
// Latency: write lands on the clock edge; read data follows index in the same cycle.
// Backpressure: none, one access per cycle, owned by the responder FSM.
module obi_sram_array
  import obi_sram_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [OBI_BE_W-1:0]   be,
  input  logic [IDX_W-1:0]      index,
  input  logic [OBI_DATA_W-1:0] wdata,
  output logic [OBI_DATA_W-1:0] rdata
);

  // Contents are deliberately not reset so a scratchpad survives a bus reset.
  logic [OBI_DATA_W-1:0] mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < OBI_BE_W; k++) begin
      if (we && be[k]) begin
        mem[index][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/obi_sram_responder.sv
// OBI device endpoint serving reads/writes from an internal DEPTH x 64-bit SRAM; optional error reporting via LUCID64_OBI_RESP_ERR_EN.
// Latency: grant after GNT_WAIT cycles; rvalid RESP_LAT (1..7) cycles after a read accept; writes complete at grant.
// Backpressure: gnt_o held low during wait-states and while a read is pending until its rvalid cycle (one read outstanding).
module obi_sram_responder
  import obi_sram_responder_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int GNT_WAIT = 0,
  parameter int RESP_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_ADDR_W-1:0] addr_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o
`ifdef LUCID64_OBI_RESP_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WC_W  = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

  state_e                state;
  logic [WC_W-1:0]       wait_cnt;
  logic [2:0]            lat_cnt;
  resp_t                 resp_q;

  logic                  resp_fire;
  logic                  wait_done;
  logic                  accept;
  logic                  addr_oor;
  logic                  mem_we;
  logic [IDX_W-1:0]      index;
  logic [OBI_DATA_W-1:0] arr_rdata;
  logic                  unused_bits;

  assign index     = addr_i[3 +: IDX_W];
  assign resp_fire = (state == RD_PEND) && (lat_cnt == 3'd0);
  assign wait_done = (wait_cnt == WC_W'(GNT_WAIT));

  // While a read is pending the only grant slot is its rvalid cycle; a request
  // granted there skips the wait-states, so the wait counter is not consulted.
  assign gnt_o  = req_i && ((state == RD_PEND) ? resp_fire : wait_done);
  assign accept = gnt_o;

`ifdef LUCID64_OBI_RESP_ERR_EN
  // Anything above the array is out of range rather than aliased.
  assign addr_oor    = |addr_i[OBI_ADDR_W-1:3+IDX_W];
  assign unused_bits = ^addr_i[2:0];
`else
  assign addr_oor    = 1'b0;
  assign unused_bits = ^{addr_i[2:0], addr_i[OBI_ADDR_W-1:3+IDX_W], resp_q.err};
`endif

  assign mem_we = accept && we_i && !addr_oor;

  obi_sram_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .be    (be_i),
    .index (index),
    .wdata (wdata_i),
    .rdata (arr_rdata)
  );

  // Grant/latency FSM plus capture of read data at the accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= '0;
      lat_cnt  <= '0;
      resp_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!we_i) begin
              state   <= RD_PEND;
              lat_cnt <= 3'(RESP_LAT - 1);
            end
          end else if (req_i) begin
            state    <= WAIT_GNT;
            wait_cnt <= WC_W'(1);
          end
        end
        WAIT_GNT: begin
          if (!req_i) begin
            // Host withdrew the request: abandon the wait.
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (accept) begin
            wait_cnt <= '0;
            if (we_i) begin
              state <= IDLE;
            end else begin
              state   <= RD_PEND;
              lat_cnt <= 3'(RESP_LAT - 1);
            end
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        RD_PEND: begin
          if (resp_fire) begin
            if (accept && !we_i) begin
              lat_cnt <= 3'(RESP_LAT - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase

      if (accept && !we_i) begin
        resp_q.err  <= addr_oor;
        resp_q.data <= addr_oor ? '0 : arr_rdata;
      end
    end
  end

  assign rvalid_o = resp_fire;
  assign rdata_o  = resp_fire ? resp_q.data : '0;
`ifdef LUCID64_OBI_RESP_ERR_EN
  assign err_o    = resp_fire && resp_q.err;
`endif

endmodule

// File: tb/tb_obi_sram_responder.sv
// Scoreboard bench for obi_sram_responder: two instances (GNT_WAIT=0/RESP_LAT=1 and GNT_WAIT=2/RESP_LAT=3).
// Latency: expected read data queued at grant, popped by per-instance monitors on each rvalid.
// Backpressure: driver holds requests until gnt and bounds every wait.
module tb_obi_sram_responder;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [2];
  logic        we     [2];
  logic [7:0]  be     [2];
  logic [63:0] addr   [2];
  logic [63:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [63:0] rdata  [2];
`ifdef LUCID64_OBI_RESP_ERR_EN
  logic        err    [2];
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  logic rv;

  always #5 clk = ~clk;

  obi_sram_responder #(.DEPTH(1024), .GNT_WAIT(0), .RESP_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0])
`ifdef LUCID64_OBI_RESP_ERR_EN
    , .err_o(err[0])
`endif
  );

  obi_sram_responder #(.DEPTH(1024), .GNT_WAIT(2), .RESP_LAT(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1])
`ifdef LUCID64_OBI_RESP_ERR_EN
    , .err_o(err[1])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor for instance 0: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rvalid[0] === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid0_unexpected actual=1 required=0");
      end else begin
        e0 = q0.pop_front();
        chk("rdata0", rdata[0], e0.data);
`ifdef LUCID64_OBI_RESP_ERR_EN
        chk("err0", {63'd0, err[0]}, {63'd0, e0.err});
`endif
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin
    if (rvalid[1] === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid1_unexpected actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        chk("rdata1", rdata[1], e1.data);
`ifdef LUCID64_OBI_RESP_ERR_EN
        chk("err1", {63'd0, err[1]}, {63'd0, e1.err});
`endif
      end
    end
  end

  // Issue one request, hold it until granted, queue the read expectation.
  task automatic do_req(input int d, input logic w, input logic [7:0] b,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err,
                        input int exp_wait, input string nm, output logic rv_at_gnt);
    int   waits = 0;
    bit   done  = 0;
    bit   got   = 0;
    exp_t e;
    rv_at_gnt = 1'b0;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    while (!done) begin
      @(negedge clk);
      if (gnt[d] === 1'b1) begin
        done = 1;
        got  = 1;
        rv_at_gnt = rvalid[d];
      end else begin
        waits++;
        if (waits > 50) begin
          checks++;
          errors++;
          $display("FAIL %s_gnt_timeout actual=no_gnt required=gnt", nm);
          done = 1;
        end
      end
    end
    if (got && !w) begin
      e.data = exp_rd;
      e.err  = exp_err;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (got && exp_wait >= 0) chk({nm, "_gnt_wait"}, 64'(waits), 64'(exp_wait));
    @(posedge clk);
    #1;
    req[d] = 1'b0;
  endtask

  // Count cycles from the accept edge to rvalid, then resync after the next edge.
  task automatic rv_lat(input int d, input int exp_lat, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rvalid[d] !== 1'b1 && n < 20);
    chk(nm, 64'(n), 64'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 8'h00; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_gnt%0d", i), {63'd0, gnt[i]}, 64'd0);
      chk($sformatf("reset_rvalid%0d", i), {63'd0, rvalid[i]}, 64'd0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 64'd0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Instance 0: same-cycle grant, one-cycle read latency.
    do_req(0, 1'b1, 8'hFF, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 0, "wr10", rv);
    do_req(0, 1'b0, 8'hFF, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, "rd10", rv);
    rv_lat(0, 1, "rd10_lat");
    do_req(0, 1'b1, 8'h0F, 64'h10, 64'h11111111_22222222, 64'h0, 1'b0, 0, "wr_part", rv);
    do_req(0, 1'b0, 8'h00, 64'h10, 64'h0, 64'hDEADBEEF_22222222, 1'b0, 0, "rd_part", rv);
    rv_lat(0, 1, "rd_part_lat");
    do_req(0, 1'b1, 8'h00, 64'h10, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, 0, "wr_be0", rv);
    do_req(0, 1'b0, 8'hFF, 64'h10, 64'h0, 64'hDEADBEEF_22222222, 1'b0, 0, "rd_be0", rv);
    rv_lat(0, 1, "rd_be0_lat");
    do_req(0, 1'b1, 8'hFF, 64'h18, 64'h0A0B0C0D_01020304, 64'h0, 1'b0, 0, "wr18", rv);
    // Back-to-back reads: each new read is granted in the previous read's rvalid cycle.
    do_req(0, 1'b0, 8'hFF, 64'h10, 64'h0, 64'hDEADBEEF_22222222, 1'b0, 0, "b2b0_a", rv);
    do_req(0, 1'b0, 8'hFF, 64'h18, 64'h0, 64'h0A0B0C0D_01020304, 1'b0, 0, "b2b0_b", rv);
    chk("b2b0_b_rvalid_at_gnt", {63'd0, rv}, 64'd1);
    do_req(0, 1'b0, 8'hFF, 64'h10, 64'h0, 64'hDEADBEEF_22222222, 1'b0, 0, "b2b0_c", rv);
    chk("b2b0_c_rvalid_at_gnt", {63'd0, rv}, 64'd1);
    rv_lat(0, 1, "b2b0_last_lat");
    do_req(0, 1'b1, 8'hFF, 64'h0, 64'h5555AAAA_5555AAAA, 64'h0, 1'b0, 0, "wr0", rv);
`ifdef LUCID64_OBI_RESP_ERR_EN
    do_req(0, 1'b0, 8'hFF, 64'h2000, 64'h0, 64'h0, 1'b1, 0, "rd_oor", rv);
    rv_lat(0, 1, "rd_oor_lat");
    do_req(0, 1'b1, 8'hFF, 64'h2000, 64'h12345678_9ABCDEF0, 64'h0, 1'b0, 0, "wr_oor", rv);
    do_req(0, 1'b0, 8'hFF, 64'h0, 64'h0, 64'h5555AAAA_5555AAAA, 1'b0, 0, "rd0_after_oor", rv);
    rv_lat(0, 1, "rd0_after_oor_lat");
`else
    // 0x2000 aliases word 0 when the index wraps modulo DEPTH.
    do_req(0, 1'b1, 8'hFF, 64'h2000, 64'h12345678_9ABCDEF0, 64'h0, 1'b0, 0, "wr_wrap", rv);
    do_req(0, 1'b0, 8'hFF, 64'h0, 64'h0, 64'h12345678_9ABCDEF0, 1'b0, 0, "rd0_wrap", rv);
    rv_lat(0, 1, "rd0_wrap_lat");
`endif

    // Instance 1: two grant wait-states, three-cycle read latency.
    do_req(1, 1'b1, 8'hFF, 64'h40, 64'h01234567_89ABCDEF, 64'h0, 1'b0, 2, "wr40", rv);
    do_req(1, 1'b0, 8'hFF, 64'h40, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 2, "rd40", rv);
    rv_lat(1, 3, "rd40_lat");
    do_req(1, 1'b0, 8'hFF, 64'h40, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 2, "b2b1_a", rv);
    do_req(1, 1'b0, 8'hFF, 64'h40, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 2, "b2b1_b", rv);
    chk("b2b1_b_rvalid_at_gnt", {63'd0, rv}, 64'd1);
    rv_lat(1, 3, "b2b1_lat");

    // Reset between read accept and rvalid, with a further read request waiting.
    do_req(1, 1'b0, 8'hFF, 64'h40, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 2, "rd_rst", rv);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 64'h40;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt1", {63'd0, gnt[1]}, 64'd0);
    chk("rst_mid_rvalid1", {63'd0, rvalid[1]}, 64'd0);
    chk("rst_mid_rdata1", rdata[1], 64'd0);
    q1.delete();
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    do_req(1, 1'b0, 8'hFF, 64'h40, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 2, "rd40_after_rst", rv);
    rv_lat(1, 3, "rd40_after_rst_lat");
    do_req(0, 1'b0, 8'hFF, 64'h18, 64'h0, 64'h0A0B0C0D_01020304, 1'b0, 0, "rd18_after_rst", rv);
    rv_lat(0, 1, "rd18_after_rst_lat");

    repeat (5) @(posedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
